// File: rtl/wb_clint.sv
// wb_clint: pipelined Wishbone slave exposing MSIP and mirroring core mtime/mtimecmp,
// with byte-lane write merge, write-back strobes and same-register forwarding.
module wb_clint #(
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
    parameter logic [15:0] MSIP_OFF  = 16'h0000,
    parameter logic [15:0] MTCMP_OFF = 16'h4000,
    parameter logic [15:0] MTIME_OFF = 16'hBFF8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [63:0] i_wb_adr,
    input  logic [63:0] i_wb_dat,
    output logic [63:0] o_wb_dat,
    input  logic        i_wb_we,
    input  logic [7:0]  i_wb_sel,
    input  logic        i_wb_stb,
    input  logic        i_wb_cyc,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    input  logic [63:0] i_cpu_mtime,
    input  logic [63:0] i_cpu_mtimecmp,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_mtime_we,
    output logic        o_mtimecmp_we,
    output logic        o_msip
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t state_q, state_d;
    logic [63:3] adr_q;
    logic [63:0] dat_q, mtime_q, mtcmp_q, mask, old_mt, old_cmp, rdata;
    logic [7:0]  sel_q;
    logic we_q, msip_q, mt_pulse_q, cmp_pulse_q, fwd_mt_q, fwd_cmp_q;
    logic accept, resp, hit, is_msip, is_mt, is_cmp;

    assign accept  = i_wb_cyc & i_wb_stb & (state_q == IDLE);
    assign resp    = (state_q == RESP) & i_wb_cyc & ~i_reset;
    assign hit     = adr_q[63:16] == BASE_ADDR[63:16];
    assign is_msip = hit & (adr_q[15:3] == MSIP_OFF[15:3]);
    assign is_cmp  = hit & (adr_q[15:3] == MTCMP_OFF[15:3]);
    assign is_mt   = hit & (adr_q[15:3] == MTIME_OFF[15:3]);
    // The core only reflects a write one cycle after the strobe, so a request
    // accepted right then must see the value we just drove, not i_cpu_*.
    assign old_mt  = fwd_mt_q ? mtime_q : i_cpu_mtime;
    assign old_cmp = fwd_cmp_q ? mtcmp_q : i_cpu_mtimecmp;
    assign o_msip  = msip_q;

    always_comb begin
        mask = '0;
        for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{sel_q[b]}};
    end

    always_comb begin
        state_d       = (state_q == IDLE && accept) ? RESP : IDLE;
        o_wb_stall    = state_q == RESP;
        o_wb_ack      = resp;
        o_mtime_we    = resp & we_q & is_mt & (|sel_q);
        o_mtimecmp_we = resp & we_q & is_cmp & (|sel_q);
        o_mtime       = o_mtime_we ? ((old_mt & ~mask) | (dat_q & mask)) : mtime_q;
        o_mtimecmp    = o_mtimecmp_we ? ((old_cmp & ~mask) | (dat_q & mask)) : mtcmp_q;
        rdata         = is_mt ? old_mt : is_cmp ? old_cmp : is_msip ? {63'b0, msip_q} : 64'b0;
        o_wb_dat      = (resp & ~we_q) ? rdata : 64'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            mtime_q     <= '0;
            mtcmp_q     <= '0;
            msip_q      <= 1'b0;
            mt_pulse_q  <= 1'b0;
            cmp_pulse_q <= 1'b0;
            fwd_mt_q    <= 1'b0;
            fwd_cmp_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mtime_q     <= o_mtime;
            mtcmp_q     <= o_mtimecmp;
            mt_pulse_q  <= o_mtime_we;
            cmp_pulse_q <= o_mtimecmp_we;
            if (accept) begin
                adr_q     <= i_wb_adr[63:3];
                dat_q     <= i_wb_dat;
                sel_q     <= i_wb_sel;
                we_q      <= i_wb_we;
                fwd_mt_q  <= mt_pulse_q;
                fwd_cmp_q <= cmp_pulse_q;
            end
            if (resp & we_q & is_msip & sel_q[0]) msip_q <= dat_q[0];
        end
    end
endmodule
